dot_product_feeder: RTL

Upstream sequencer for the 8×8 dot-product stage. It runs in two phases:
- **Load:** accepts a B vector set over a valid/ready stream and writes it into the stage's BRAM.
- **Compute:** streams A vectors against the stored B, generating BRAM read addresses and `first`/`last` framing for a programmable number of repetitions.

Input bubbles are zero-stuffed so the downstream accumulator never sees a gap inside a dot product. All downstream-facing outputs are registered and connect directly to the dot-product stage inputs.

---
 rtl/dot_product_feeder_pkg.sv | 17 +
 rtl/dot_product_feeder_cnt.sv | 31 +++
 rtl/dot_product_feeder.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/dot_product_feeder_pkg.sv
// rtl/dot_product_feeder_pkg.sv - shared sizes and FSM state type for the dot-product feeder
package dot_product_feeder_pkg;

  // Defaults shared with the dot-product top.
  localparam int N_DEF     = 8;              // integer width (bits)
  localparam int M_DEF     = 8;              // parallel multiplies per vector
  localparam int A_DEF     = 10;             // BRAM address bits
  localparam int R_DEF     = 16;             // repetition-count width
  localparam int VEC_W_DEF = M_DEF * N_DEF;  // packed vector width

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOAD    = 2'd1,
    ST_COMPUTE = 2'd2
  } state_t;

endpackage

// File: rtl/dot_product_feeder_cnt.sv
// rtl/dot_product_feeder_cnt.sv - loadable up-counter with terminal-count flag and wrap to zero
module dot_product_feeder_cnt #(
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_en,
  input  logic [W-1:0] i_term,
  output logic [W-1:0] o_count,
  output logic         o_tc
);

  logic [W-1:0] count_q;

  assign o_count = count_q;
  assign o_tc    = (count_q == i_term);

  // Load has priority; an enabled count at the terminal value wraps to zero.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      count_q <= '0;
    end else if (i_load) begin
      count_q <= i_load_val;
    end else if (i_en) begin
      count_q <= o_tc ? '0 : count_q + W'(1);
    end
  end

endmodule

// File: rtl/dot_product_feeder.sv
// rtl/dot_product_feeder.sv - B-load / A-compute sequencer feeding the 8x8 dot-product stage (option: DOT_PRODUCT_FEEDER_BUBBLE_COUNT_EN)
module dot_product_feeder
  import dot_product_feeder_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int M = M_DEF,
  parameter int A = A_DEF,
  parameter int R = R_DEF
) (
  input  logic           i_clk,
  input  logic           i_reset,
  input  logic           i_start,
  input  logic [A:0]     i_len,
  input  logic [R-1:0]   i_reps,
  input  logic [M*N-1:0] i_b_data,
  input  logic           i_b_valid,
  output logic           o_b_ready,
  input  logic [M*N-1:0] i_a_data,
  input  logic           i_a_valid,
  output logic           o_a_ready,
  output logic [M*N-1:0] o_b,
  output logic [A-1:0]   o_b_addr,
  output logic           o_wren,
  output logic [M*N-1:0] o_a,
  output logic           o_first,
  output logic           o_last,
`ifdef DOT_PRODUCT_FEEDER_BUBBLE_COUNT_EN
  output logic [15:0]    o_bubbles,
`endif
  output logic           o_busy,
  output logic           o_done
);

  localparam int VW = M * N;
  localparam logic [A:0] MAX_LEN = {1'b1, {A{1'b0}}};

  state_t         state_q, state_d;
  logic [A-1:0]   len_m1_q;
  logic [R-1:0]   reps_m1_q;
  logic [VW-1:0]  b_q, b_d, a_q, a_d;
  logic [A-1:0]   addr_q, addr_d;
  logic           wren_q, wren_d, first_q, first_d, last_q, last_d, done_q, done_d;

  logic           start_ok, idx_load, idx_en, rep_en;
  logic [A-1:0]   idx;
  logic           idx_tc, rep_tc;
  logic [R-1:0]   rep_cnt;
  logic           len_ok, reps_ok, b_fire, a_fire;

  assign len_ok  = (i_len != '0) && (i_len <= MAX_LEN);
  assign reps_ok = (i_reps != '0);
  assign b_fire  = i_b_valid && o_b_ready;
  assign a_fire  = i_a_valid && o_a_ready;

  assign o_b_ready = (state_q == ST_LOAD);
  assign o_a_ready = (state_q == ST_COMPUTE);
  assign o_busy    = (state_q != ST_IDLE);
  assign o_b       = b_q;
  assign o_b_addr  = addr_q;
  assign o_wren    = wren_q;
  assign o_a       = a_q;
  assign o_first   = first_q;
  assign o_last    = last_q;
  assign o_done    = done_q;

  // Load/compute beat index; terminal count marks the last element of a dot product.
  dot_product_feeder_cnt #(.W(A)) u_idx_cnt (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_load     (idx_load),
    .i_load_val ({A{1'b0}}),
    .i_en       (idx_en),
    .i_term     (len_m1_q),
    .o_count    (idx),
    .o_tc       (idx_tc)
  );

  // Repetition counter; terminal count marks the final dot product.
  dot_product_feeder_cnt #(.W(R)) u_rep_cnt (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_load     (idx_load),
    .i_load_val ({R{1'b0}}),
    .i_en       (rep_en),
    .i_term     (reps_m1_q),
    .o_count    (rep_cnt),
    .o_tc       (rep_tc)
  );

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_reset) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // Next state plus next values of every registered downstream output.
  always_comb begin
    state_d  = state_q;
    start_ok = 1'b0;
    idx_load = 1'b0;
    idx_en   = 1'b0;
    rep_en   = 1'b0;
    b_d      = b_q;
    addr_d   = addr_q;
    wren_d   = 1'b0;
    a_d      = '0;     // bubbles and idle cycles feed a zero vector
    first_d  = 1'b0;
    last_d   = 1'b0;
    done_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_start && len_ok && reps_ok) begin
          start_ok = 1'b1;
          idx_load = 1'b1;
          state_d  = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (b_fire) begin
          b_d    = i_b_data;
          addr_d = idx;
          wren_d = 1'b1;
          idx_en = 1'b1;
          if (idx_tc) state_d = ST_COMPUTE;
        end
      end
      ST_COMPUTE: begin
        if (a_fire) begin
          a_d     = i_a_data;
          addr_d  = idx;
          first_d = (idx == '0);
          last_d  = idx_tc;
          idx_en  = 1'b1;
          if (idx_tc) begin
            rep_en = 1'b1;
            if (rep_tc) begin
              done_d  = 1'b1;
              state_d = ST_IDLE;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output registers and the length/repetition terms latched on an accepted start.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      len_m1_q  <= '0;
      reps_m1_q <= '0;
      b_q       <= '0;
      addr_q    <= '0;
      wren_q    <= 1'b0;
      a_q       <= '0;
      first_q   <= 1'b0;
      last_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      if (start_ok) begin
        // len==2^A has zero low bits, so len-1 wraps to all ones in A bits.
        len_m1_q  <= i_len[A-1:0] - A'(1);
        reps_m1_q <= i_reps - R'(1);
      end
      b_q     <= b_d;
      addr_q  <= addr_d;
      wren_q  <= wren_d;
      a_q     <= a_d;
      first_q <= first_d;
      last_q  <= last_d;
      done_q  <= done_d;
    end
  end

`ifdef DOT_PRODUCT_FEEDER_BUBBLE_COUNT_EN
  logic [15:0] bubbles_q;
  logic        bubble;

  assign bubble    = (state_q == ST_COMPUTE) && !a_fire && (idx != '0);
  assign o_bubbles = bubbles_q;

  // Saturating count of zero-stuffed cycles inside a dot product.
  always_ff @(posedge i_clk) begin
    if (i_reset || start_ok) bubbles_q <= '0;
    else if (bubble && (bubbles_q != 16'hFFFF)) bubbles_q <= bubbles_q + 16'd1;
  end
`endif

endmodule
